// File: rtl/wspad_pkg.sv
// -----------------------------------------------------------------------------
// wspad_pkg
// Shared definitions for the PE weight scratchpad receiver.
//   wspad_state_e : control state of the receiver (EMPTY / LOADING / READY)
//   wspad_depth() : scratchpad capacity in words for a given filter side
//                   (kernel_size**2 + 1)
// -----------------------------------------------------------------------------
package wspad_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } wspad_state_e;

    function automatic int wspad_depth(input int kernel_size);
        return kernel_size * kernel_size + 1;
    endfunction

endpackage

// File: rtl/wspad_mem.sv
// -----------------------------------------------------------------------------
// wspad_mem
// DATA_W x DEPTH weight storage with one write port and one registered read
// port. A read and a write to the same address in the same cycle return the
// old contents (read-before-write). Reads of addresses >= DEPTH return 0.
// Only the read data register is reset; the array contents are not.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (read data register only)
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   re_i     in   read enable; rdata_o updates on the next rising edge
//   raddr_i  in   read address
//   rdata_o  out  registered read data, holds when re_i is low
// -----------------------------------------------------------------------------
module wspad_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < DEPTH_A)) begin
            mem[waddr_i[IDX_W-1:0]] <= wdata_i;
        end
    end

    // Non-blocking read of the array in the same edge as the write gives
    // read-before-write for colliding addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            if (raddr_i < DEPTH_A) begin
                rdata_q <= mem[raddr_i[IDX_W-1:0]];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_spad_rx.sv
// -----------------------------------------------------------------------------
// weight_spad_rx
// Receiver end of the weight load stream into a PE weight scratchpad. Beats
// from the weight router are written sequentially from address 0; a burst
// ends on the first cycle load_en_spad is low, after which the stored words
// are flagged valid. A one-cycle-latency read port feeds the MAC datapath.
//
// Configuration macro: WSPAD_OVF_DET_EN
//   defined   : beats past capacity are dropped, wspad_ovf port flags it
//               (sticky until clear_spad or reset)
//   undefined : the write pointer wraps and overwrites from address 0
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-low reset
//   w_data_spad    in   incoming weight beat
//   load_en_spad   in   beat valid
//   clear_spad     in   synchronous discard of stored burst
//   r_addr_spad    in   PE read address
//   read_req_spad  in   PE read strobe
//   r_data_spad    out  read data, valid one cycle after read_req_spad
//   r_valid_spad   out  read_req_spad delayed one cycle
//   weights_valid  out  complete burst stored and readable
//   wght_count     out  beats stored in last/current burst (saturating)
//   spad_busy      out  high while loading a burst
//   spad_state     out  current control state (debug observation)
//   wspad_ovf      out  overflow seen (only with WSPAD_OVF_DET_EN)
//
// Stream handshake: load_en_spad is a valid-only strobe with no ready; every
// cycle it is high carries one beat that is accepted unconditionally (unless
// clear_spad is high in the same cycle, which drops it).
// -----------------------------------------------------------------------------
module weight_spad_rx
    import wspad_pkg::*;
#(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int kernel_size        = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITWIDTH-1:0]      w_data_spad,
    input  logic                          load_en_spad,
    input  logic                          clear_spad,
    input  logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad,
    input  logic                          read_req_spad,
    output logic [DATA_BITWIDTH-1:0]      r_data_spad,
    output logic                          r_valid_spad,
    output logic                          weights_valid,
    output logic [ADDR_BITWIDTH_SPAD-1:0] wght_count,
    output logic                          spad_busy,
    output wspad_state_e                  spad_state
`ifdef WSPAD_OVF_DET_EN
    ,
    output logic                          wspad_ovf
`endif
);

    localparam int AW    = ADDR_BITWIDTH_SPAD;
    localparam int DEPTH = wspad_depth(kernel_size);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    wspad_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wv_q, wv_d;
    logic          r_valid_q;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
`ifdef WSPAD_OVF_DET_EN
    logic          ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            wv_q      <= 1'b0;
            r_valid_q <= 1'b0;
`ifdef WSPAD_OVF_DET_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            wv_q      <= wv_d;
            r_valid_q <= read_req_spad;
`ifdef WSPAD_OVF_DET_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        wv_d      = wv_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
`ifdef WSPAD_OVF_DET_EN
        ovf_d     = ovf_q;
`endif

        if (clear_spad) begin
            state_d  = EMPTY;
            wr_ptr_d = '0;
            cnt_d    = '0;
            wv_d     = 1'b0;
`ifdef WSPAD_OVF_DET_EN
            ovf_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                EMPTY, READY: begin
                    // First beat of a new burst always lands at address 0.
                    if (load_en_spad) begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_ptr_d  = ONE_A;
                        cnt_d     = ONE_A;
                        wv_d      = 1'b0;
                        state_d   = LOADING;
                    end
                end
                LOADING: begin
                    if (load_en_spad) begin
`ifdef WSPAD_OVF_DET_EN
                        if (wr_ptr_q == DEPTH_A) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + ONE_A;
                            cnt_d    = cnt_q + ONE_A;
                        end
`else
                        // Wrap straight to 0 after the last slot so the beat
                        // arriving at capacity overwrites address 0.
                        mem_we   = 1'b1;
                        wr_ptr_d = (wr_ptr_q == LAST_A) ? '0 : wr_ptr_q + ONE_A;
                        cnt_d    = (cnt_q == DEPTH_A) ? cnt_q : cnt_q + ONE_A;
`endif
                    end else begin
                        state_d  = READY;
                        wv_d     = 1'b1;
                        wr_ptr_d = '0;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    wv_d     = 1'b0;
                end
            endcase
        end
    end

    wspad_mem #(
        .DATA_W (DATA_BITWIDTH),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (w_data_spad),
        .re_i    (read_req_spad),
        .raddr_i (r_addr_spad),
        .rdata_o (r_data_spad)
    );

    assign r_valid_spad  = r_valid_q;
    assign weights_valid = wv_q;
    assign wght_count    = cnt_q;
    assign spad_busy     = (state_q == LOADING);
    assign spad_state    = state_q;
`ifdef WSPAD_OVF_DET_EN
    assign wspad_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_weight_spad_rx.sv
// -----------------------------------------------------------------------------
// tb_weight_spad_rx
// Self-checking bench for weight_spad_rx: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// burst-level behavioural model of the scratchpad.
// -----------------------------------------------------------------------------
module tb_weight_spad_rx;
    import wspad_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int KS    = 3;
    localparam int DEPTH = KS * KS + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] w_data_spad = '0;
    logic          load_en_spad = 1'b0;
    logic          clear_spad = 1'b0;
    logic [AW-1:0] r_addr_spad = '0;
    logic          read_req_spad = 1'b0;
    logic [DW-1:0] r_data_spad;
    logic          r_valid_spad;
    logic          weights_valid;
    logic [AW-1:0] wght_count;
    logic          spad_busy;
    wspad_state_e  spad_state;
`ifdef WSPAD_OVF_DET_EN
    logic          wspad_ovf;
`endif

    always #5 clk = ~clk;

    weight_spad_rx #(
        .DATA_BITWIDTH      (DW),
        .ADDR_BITWIDTH_SPAD (AW),
        .kernel_size        (KS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .w_data_spad   (w_data_spad),
        .load_en_spad  (load_en_spad),
        .clear_spad    (clear_spad),
        .r_addr_spad   (r_addr_spad),
        .read_req_spad (read_req_spad),
        .r_data_spad   (r_data_spad),
        .r_valid_spad  (r_valid_spad),
        .weights_valid (weights_valid),
        .wght_count    (wght_count),
        .spad_busy     (spad_busy),
        .spad_state    (spad_state)
`ifdef WSPAD_OVF_DET_EN
        ,
        .wspad_ovf     (wspad_ovf)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Burst-level view: a burst is a run of load cycles; beat n of a burst
    // goes to slot n (dropped past capacity, or modulo capacity when wrapping).
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            m_loading, m_wv, m_rvalid, m_rknown, m_ovf;
    int            m_beats, m_cnt;
    logic [DW-1:0] m_rdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_loading = 0; m_wv = 0; m_beats = 0; m_cnt = 0;
            m_rdata = '0; m_rvalid = 0; m_rknown = 1; m_ovf = 0;
        end else begin
            m_rvalid = read_req_spad;
            if (read_req_spad) begin
                if (int'(r_addr_spad) < DEPTH) begin
                    m_rdata  = m_mem[int'(r_addr_spad)];
                    m_rknown = m_known[int'(r_addr_spad)];
                end else begin
                    m_rdata  = '0;
                    m_rknown = 1;
                end
            end
            if (clear_spad) begin
                m_loading = 0; m_wv = 0; m_beats = 0; m_cnt = 0; m_ovf = 0;
            end else if (load_en_spad) begin
                if (!m_loading) begin
                    m_beats = 0; m_wv = 0; m_loading = 1;
                end
`ifdef WSPAD_OVF_DET_EN
                if (m_beats < DEPTH) begin
                    m_mem[m_beats] = w_data_spad; m_known[m_beats] = 1;
                end else begin
                    m_ovf = 1;
                end
`else
                m_mem[m_beats % DEPTH] = w_data_spad; m_known[m_beats % DEPTH] = 1;
`endif
                m_beats++;
                m_cnt = (m_beats < DEPTH) ? m_beats : DEPTH;
            end else if (m_loading) begin
                m_loading = 0; m_wv = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset) begin
            chk("busy", 32'(spad_busy), 32'(m_loading));
            chk("weights_valid", 32'(weights_valid), 32'(m_wv));
            chk("wght_count", 32'(wght_count), 32'(m_cnt));
            chk("r_valid", 32'(r_valid_spad), 32'(m_rvalid));
            chk("state", 32'(spad_state), m_loading ? 32'd1 : (m_wv ? 32'd2 : 32'd0));
            if (m_rknown) chk("r_data", 32'(r_data_spad), 32'(m_rdata));
`ifdef WSPAD_OVF_DET_EN
            chk("wspad_ovf", 32'(wspad_ovf), 32'(m_ovf));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        w_data_spad = d; load_en_spad = 1'b1;
        step();
    endtask

    task automatic idle();
        load_en_spad = 1'b0;
        step();
    endtask

    task automatic rd(input int a, input logic [DW-1:0] exp, input string nm);
        r_addr_spad = AW'(a); read_req_spad = 1'b1;
        step();
        read_req_spad = 1'b0;
        chk(nm, 32'(r_data_spad), 32'(exp));
        chk({nm, "_rv"}, 32'(r_valid_spad), 32'd1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        #1;
        chk("rst_busy", 32'(spad_busy), 32'd0);
        chk("rst_wv", 32'(weights_valid), 32'd0);
        chk("rst_cnt", 32'(wght_count), 32'd0);
        chk("rst_rdata", 32'(r_data_spad), 32'd0);
        chk("rst_rvalid", 32'(r_valid_spad), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        step();

        // Basic load
        for (int i = 0; i < 10; i++) beat(DW'(16'h0101 + i));
        chk("basic_wv_last_beat", 32'(weights_valid), 32'd0);
        idle();
        chk("basic_wv", 32'(weights_valid), 32'd1);
        chk("basic_cnt", 32'(wght_count), 32'd10);
        for (int i = 0; i < 10; i++) rd(i, DW'(16'h0101 + i), $sformatf("basic_rd%0d", i));

        // Reload
        beat(16'hAAA0);
        chk("reload_wv_drop", 32'(weights_valid), 32'd0);
        beat(16'hAAA1);
        beat(16'hAAA2);
        idle();
        chk("reload_cnt", 32'(wght_count), 32'd3);
        rd(0, 16'hAAA0, "reload_rd0");
        rd(1, 16'hAAA1, "reload_rd1");
        rd(2, 16'hAAA2, "reload_rd2");
        rd(3, 16'h0104, "reload_rd3");

        // Read/write collision on addr 2
        beat(16'hB000);
        beat(16'hB001);
        r_addr_spad = 9'd2; read_req_spad = 1'b1;
        beat(16'hB002);
        read_req_spad = 1'b0;
        chk("collide_old", 32'(r_data_spad), 32'h0000AAA2);
        idle();
        rd(2, 16'hB002, "collide_new");

        // Clear priority over a simultaneous beat
        beat(16'hC000);
        beat(16'hC001);
        beat(16'hC002);
        clear_spad = 1'b1;
        beat(16'hDEAD);
        clear_spad = 1'b0; load_en_spad = 1'b0;
        chk("clr_busy", 32'(spad_busy), 32'd0);
        chk("clr_cnt", 32'(wght_count), 32'd0);
        chk("clr_wv", 32'(weights_valid), 32'd0);
        chk("clr_state", 32'(spad_state), 32'(EMPTY));
        rd(3, 16'h0104, "clr_rd3");

        // Overflow: 12-beat burst
        for (int i = 0; i < 12; i++) beat(DW'(16'hE000 + i));
        idle();
        chk("ovf_cnt", 32'(wght_count), 32'd10);
`ifdef WSPAD_OVF_DET_EN
        chk("ovf_flag", 32'(wspad_ovf), 32'd1);
        rd(0, 16'hE000, "ovf_rd0");
        rd(1, 16'hE001, "ovf_rd1");
`else
        rd(0, 16'hE00A, "wrap_rd0");
        rd(1, 16'hE00B, "wrap_rd1");
`endif
        rd(9, 16'hE009, "ovf_rd9");
        rd(12, 16'h0000, "oor_rd12");

        // Async reset mid-burst
        for (int i = 0; i < 3; i++) beat(DW'(16'hF000 + i));
        chk("pre_rst_busy", 32'(spad_busy), 32'd1);
        w_data_spad = 16'hF003; load_en_spad = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(spad_busy), 32'd0);
        chk("arst_cnt", 32'(wght_count), 32'd0);
        chk("arst_wv", 32'(weights_valid), 32'd0);
        chk("arst_rdata", 32'(r_data_spad), 32'd0);
        chk("arst_rvalid", 32'(r_valid_spad), 32'd0);
        load_en_spad = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        step();
        for (int i = 0; i < 10; i++) beat(DW'(16'h1100 + i));
        idle();
        chk("post_rst_cnt", 32'(wght_count), 32'd10);
        for (int i = 0; i < 10; i++) rd(i, DW'(16'h1100 + i), $sformatf("post_rst_rd%0d", i));

        // Randomized traffic against the model
        begin
            bit in_burst = 0;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 3) == 0) in_burst = !in_burst;
                load_en_spad  = in_burst;
                w_data_spad   = DW'($urandom);
                clear_spad    = ($urandom_range(0, 39) == 0);
                read_req_spad = $urandom_range(0, 1) == 1;
                r_addr_spad   = AW'($urandom_range(0, 12));
                step();
            end
        end
        load_en_spad = 1'b0; clear_spad = 1'b0; read_req_spad = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
